// File: rtl/riscv_pkg.sv
// Shared RV core constants and types, used by the register file and the ALU.
// Optional build macro consumed by users of this package: REGFILE_BYPASS_EN.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ZERO_REG   = 0;

    typedef logic [XLEN-1:0]       xword_t;
    typedef logic [REG_ADDR_W-1:0] regidx_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT
    } alu_op_e;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: x0 masking plus optional write forwarding.
// Forwarding compare exists only when REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN       = riscv_pkg::XLEN,
    parameter int unsigned REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] raddr,
    input  logic [XLEN-1:0]       stored,
`ifdef REGFILE_BYPASS_EN
    input  logic                  wen,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
`endif
    output logic [XLEN-1:0]       rdata
);

    always_comb begin
        rdata = stored;
`ifdef REGFILE_BYPASS_EN
        if (wen && (raddr == waddr)) begin
            rdata = wdata;
        end
`endif
        if (raddr == REG_ADDR_W'(ZERO_REG)) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/regfile.sv
// 2^REG_ADDR_W x XLEN register file, two combinational reads, one clocked write, x0 hardwired.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN       = riscv_pkg::XLEN,
    parameter int unsigned REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [XLEN-1:0]       rdata1,
    output logic [XLEN-1:0]       rdata2,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata
);

    localparam int unsigned NREGS = 1 << REG_ADDR_W;

    logic [XLEN-1:0] regs [NREGS];
    logic            wen;

    // Qualifying with rst_n keeps forwarded data off the read ports during reset.
    assign wen = we && rst_n && (waddr != REG_ADDR_W'(ZERO_REG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wen) begin
            regs[waddr] <= wdata;
        end
    end

    regfile_read_port #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_rp1 (
        .raddr  (raddr1),
        .stored (regs[raddr1]),
`ifdef REGFILE_BYPASS_EN
        .wen    (wen),
        .waddr  (waddr),
        .wdata  (wdata),
`endif
        .rdata  (rdata1)
    );

    regfile_read_port #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_rp2 (
        .raddr  (raddr2),
        .stored (regs[raddr2]),
`ifdef REGFILE_BYPASS_EN
        .wen    (wen),
        .waddr  (waddr),
        .wdata  (wdata),
`endif
        .rdata  (rdata2)
    );

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mdl [32];

    regfile #(
        .XLEN       (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_rd(input string tag, input int port, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Let the combinational reads settle, then retire every pending expectation.
    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, (e.port == 1) ? rdata1 : rdata2, e.exp);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic read2(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2);
        raddr1 = a1;
        raddr2 = a2;
        expect_rd({tag, "_p1"}, 1, e1);
        expect_rd({tag, "_p2"}, 2, e2);
        drain();
    endtask

    initial begin
        logic [32:0] sum;
        logic        zf;
        logic [4:0]  a;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] d;
        logic        w;
        logic [31:0] e1;
        logic [31:0] e2;

        rst_n  = 1'b0;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = '0;
        raddr2 = '0;

        // Reset state.
        #2;
        read2("rst0_r0", 5'd0, 5'd1, 32'h0, 32'h0);
        read2("rst0_r31", 5'd31, 5'd31, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read next cycle.
        do_write(5'd5, 32'hdead_beef);
        read2("wr5", 5'd5, 5'd0, 32'hdead_beef, 32'h0);

        // Write to x0 is dropped.
        do_write(5'd0, 32'hffff_ffff);
        read2("x0", 5'd5, 5'd0, 32'hdead_beef, 32'h0);

        // we=0 leaves contents untouched.
        @(negedge clk);
        we    = 1'b0;
        waddr = 5'd5;
        wdata = 32'h0bad_0bad;
        @(negedge clk);
        read2("we0", 5'd5, 5'd5, 32'hdead_beef, 32'hdead_beef);

        // Same-cycle write/read hazard on reg 7.
        do_write(5'd7, 32'h0000_0001);
        @(negedge clk);
        we     = 1'b1;
        waddr  = 5'd7;
        wdata  = 32'h7fff_ffff;
        raddr1 = 5'd7;
        raddr2 = 5'd5;
`ifdef REGFILE_BYPASS_EN
        expect_rd("haz_p1", 1, 32'h7fff_ffff);
`else
        expect_rd("haz_p1", 1, 32'h0000_0001);
`endif
        expect_rd("haz_p2", 2, 32'hdead_beef);
        drain();
        @(negedge clk);
        we = 1'b0;
        read2("haz_after", 5'd7, 5'd7, 32'h7fff_ffff, 32'h7fff_ffff);

        // Dual-port feed into an ALU add.
        do_write(5'd1, 32'hffff_ffff);
        do_write(5'd2, 32'h0000_0001);
        read2("alu_rd", 5'd1, 5'd2, 32'hffff_ffff, 32'h0000_0001);
        sum = {1'b0, rdata1} + {1'b0, rdata2};
        zf  = (sum[31:0] == 32'h0);
        check("alu_res", sum[31:0], 32'h0);
        check("alu_zf", {31'h0, zf}, 32'h1);
        check("alu_cf", {31'h0, sum[32]}, 32'h1);

        // Randomised traffic against a reference array.
        for (int unsigned i = 0; i < 32; i++) mdl[i] = '0;
        mdl[1] = 32'hffff_ffff;
        mdl[2] = 32'h0000_0001;
        mdl[5] = 32'hdead_beef;
        mdl[7] = 32'h7fff_ffff;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a  = 5'($urandom_range(0, 31));
            d  = $urandom;
            w  = ($urandom_range(0, 3) != 0);
            r1 = (i % 4 == 0) ? a : 5'($urandom_range(0, 31));
            r2 = (i % 5 == 0) ? a : 5'($urandom_range(0, 31));
            we     = w;
            waddr  = a;
            wdata  = d;
            raddr1 = r1;
            raddr2 = r2;
            e1 = mdl[r1];
            e2 = mdl[r2];
`ifdef REGFILE_BYPASS_EN
            if (w && a != 0 && r1 == a) e1 = d;
            if (w && a != 0 && r2 == a) e2 = d;
`endif
            if (r1 == 0) e1 = '0;
            if (r2 == 0) e2 = '0;
            expect_rd("rnd_p1", 1, e1);
            expect_rd("rnd_p2", 2, e2);
            drain();
            @(posedge clk);
            if (w && a != 0) mdl[a] = d;
        end
        @(negedge clk);
        we = 1'b0;

        // Async reset with nonzero contents, asserted between edges.
        #2;
        rst_n = 1'b0;
        we    = 1'b1;
        waddr = 5'd1;
        wdata = 32'h5555_aaaa;
        read2("arst_r0", 5'd0, 5'd1, 32'h0, 32'h0);
        read2("arst_r31", 5'd31, 5'd1, 32'h0, 32'h0);
        @(negedge clk);
        we    = 1'b0;
        rst_n = 1'b1;

        // Reset asserted mid-write and held across the edge.
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd3;
        wdata = 32'h1234_5678;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        we    = 1'b0;
        read2("midwr", 5'd3, 5'd3, 32'h0, 32'h0);

        // First write after release lands.
        do_write(5'd9, 32'ha5a5_5a5a);
        read2("post_rst", 5'd9, 5'd3, 32'ha5a5_5a5a, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
